// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 serial demultiplexer/deserializer.
package demux_pkg;
  localparam int NSEL  = 3;
  localparam int NLANE = 8;

  typedef logic [NSEL-1:0]  sel_t;
  typedef logic [NLANE-1:0] frame_t;

  localparam sel_t LAST_IDX = 3'd7;

  typedef enum logic {EMPTY, FULL} hold_state_t;
endpackage

// File: rtl/demux_idx_counter.sv
// Lane index counter: wraps 7->0 on inc, can be forced to 0 or 1 for frame resync.
module demux_idx_counter
  import demux_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic load0,
  input  logic load1,
  output sel_t x,
  output logic last
);

  // load1 wins over load0 so a qualified start-of-frame bit lands in lane 0 and moves on.
  always_ff @(posedge clk) begin
    if (rst)
      x <= '0;
    else if (load1)
      x <= sel_t'(1);
    else if (load0)
      x <= '0;
    else if (inc)
      x <= x + sel_t'(1);
  end

  assign last = (x == LAST_IDX);

endmodule

// File: rtl/demux_deser.sv
// Receiving end of the 8:1 mux path: steers serial bits into an assembly register
// and presents completed frames through a valid/ready holding register.
module demux_deser
  import demux_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic Y,
  input  logic Y_valid,
  input  logic sof,
  input  logic frame_ready,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic D4,
  output logic D5,
  output logic D6,
  output logic D7,
  output logic frame_valid,
  output sel_t X,
  output logic overrun
);

  frame_t      asm_reg;
  frame_t      hold;
  frame_t      word;
  hold_state_t state;
  sel_t        idx;
  logic        last;
  logic        complete;

  demux_idx_counter u_idx (
    .clk   (clk),
    .rst   (rst),
    .inc   (Y_valid & ~sof),
    .load0 (sof & ~Y_valid),
    .load1 (Y_valid & sof),
    .x     (idx),
    .last  (last)
  );

  // Bit 7 bypasses the assembly register so the frame is ready on the same edge.
  assign complete = Y_valid & ~sof & last;
  assign word     = {Y, asm_reg[NLANE-2:0]};

  always_ff @(posedge clk) begin
    if (rst)
      asm_reg <= '0;
    else if (Y_valid) begin
      if (sof)
        asm_reg[0] <= Y;
      else
        asm_reg[idx] <= Y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      hold    <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            hold  <= word;
            state <= FULL;
          end
        end
        FULL: begin
          if (complete) begin
            if (frame_ready)
              hold <= word;
            else
              overrun <= 1'b1;
          end else if (frame_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign frame_valid = (state == FULL);
  assign X           = idx;
  assign {D7, D6, D5, D4, D3, D2, D1, D0} = hold;

endmodule

// File: tb/tb_demux_deser.sv
// Self-checking bench for demux_deser: frame-level reference model plus a
// scoreboard that checks every handed-off frame against the frame the model expected.
module tb_demux_deser;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic y = 1'b0;
  logic y_valid = 1'b0;
  logic sof = 1'b0;
  logic frame_ready = 1'b0;
  logic d0, d1, d2, d3, d4, d5, d6, d7;
  logic frame_valid;
  logic overrun;
  sel_t x;

  int checks = 0;
  int failures = 0;

  // Reference model: bits collected since the last frame boundary, plus the held frame.
  frame_t sb[$];
  bit     m_bits[$];
  frame_t m_hold = '0;
  bit     m_full = 1'b0;
  bit     m_ovr  = 1'b0;

  always #5 clk = ~clk;

  demux_deser dut (
    .clk         (clk),
    .rst         (rst),
    .Y           (y),
    .Y_valid     (y_valid),
    .sof         (sof),
    .frame_ready (frame_ready),
    .D0          (d0),
    .D1          (d1),
    .D2          (d2),
    .D3          (d3),
    .D4          (d4),
    .D5          (d5),
    .D6          (d6),
    .D7          (d7),
    .frame_valid (frame_valid),
    .X           (x),
    .overrun     (overrun)
  );

  function automatic frame_t d_bus();
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs that edge saw.
  task automatic modelStep(input bit r, input bit yv, input bit s, input bit yb, input bit fr);
    bit     done;
    frame_t w;
    done = 1'b0;
    w    = '0;
    if (r) begin
      m_bits.delete();
      sb.delete();
      m_full = 1'b0;
      m_hold = '0;
      m_ovr  = 1'b0;
      return;
    end
    if (yv && s) begin
      m_bits.delete();
      m_bits.push_back(yb);
    end else if (s) begin
      m_bits.delete();
    end else if (yv) begin
      m_bits.push_back(yb);
      if (m_bits.size() == NLANE) begin
        for (int i = 0; i < NLANE; i++) w[i] = m_bits[i];
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_full || fr) begin
        m_hold = w;
        m_full = 1'b1;
        sb.push_back(w);
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_full && fr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic checkState();
    checkOutput("X", int'(x), m_bits.size());
    checkOutput("frame_valid", int'(frame_valid), int'(m_full));
    checkOutput("overrun", int'(overrun), int'(m_ovr));
    checkOutput("D", int'(d_bus()), int'(m_hold));
  endtask

  // Drives one cycle of inputs, lets the edge happen, then compares against the model.
  task automatic applyStimulus(input bit r, input bit yv, input bit s, input bit yb, input bit fr);
    rst         = r;
    y_valid     = yv;
    sof         = s;
    y           = yb;
    frame_ready = fr;
    @(posedge clk);
    modelStep(r, yv, s, yb, fr);
    #1;
    checkState();
  endtask

  task automatic sendBits(input frame_t w, input int first, input int count, input bit fr_last, input bit fr_other);
    for (int i = first; i < first + count; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, w[i], (i == NLANE - 1) ? fr_last : fr_other);
  endtask

  // Monitor: inputs and outputs are settled at the falling edge, so a transfer is
  // recognised here and the presented frame is checked against the scoreboard head.
  initial begin
    frame_t exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && frame_valid === 1'b1 && frame_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_frame", int'(d_bus()), -1);
        end else begin
          exp = sb.pop_front();
          checkOutput("transfer_D", int'(d_bus()), int'(exp));
        end
      end
    end
  end

  initial begin
    frame_t w;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_D", int'(d_bus()), 0);
    checkOutput("reset_X", int'(x), 0);

    // Sweep pattern 0,1,0,1,... into a consumer that is not ready.
    sendBits(8'hAA, 0, 8, 1'b0, 1'b0);
    checkOutput("sweep_D", int'(d_bus()), 8'hAA);
    checkOutput("sweep_valid", int'(frame_valid), 1);

    // Second frame dropped while the first is still held.
    sendBits(8'hFF, 0, 8, 1'b0, 1'b0);
    checkOutput("overrun_D", int'(d_bus()), 8'hAA);
    checkOutput("overrun_flag", int'(overrun), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_valid", int'(frame_valid), 0);

    // Accept and complete on the same edge.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(8'h3C, 0, 8, 1'b0, 1'b0);
    sendBits(8'hC5, 0, 8, 1'b1, 1'b0);
    checkOutput("simul_D", int'(d_bus()), 8'hC5);
    checkOutput("simul_valid", int'(frame_valid), 1);
    checkOutput("simul_overrun", int'(overrun), 0);

    // Resync after a partial frame.
    sendBits(8'hFF, 0, 3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("resync_X", int'(x), 1);
    sendBits(8'h00, 1, 7, 1'b1, 1'b1);
    checkOutput("resync_D", int'(d_bus()), 8'h01);

    // Gapped delivery.
    w = 8'h96;
    for (int i = 0; i < NLANE; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, w[i], 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, ~w[i], 1'b1);
    end
    checkOutput("gaps_D", int'(d_bus()), 8'h96);

    // Reset mid-frame while a frame is held.
    sendBits(8'h5A, 0, 8, 1'b0, 1'b0);
    sendBits(8'h00, 0, 5, 1'b0, 1'b0);
    checkOutput("pre_reset_X", int'(x), 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("midreset_D", int'(d_bus()), 0);
    checkOutput("midreset_valid", int'(frame_valid), 0);
    sendBits(8'hE7, 0, 8, 1'b0, 1'b0);
    checkOutput("clean_D", int'(d_bus()), 8'hE7);

    // Randomised traffic with back-pressure, resyncs and occasional resets.
    for (int n = 0; n < 800; n++)
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
